// File: rtl/reg_write_arbiter.sv
`timescale 1ns / 1ps
// reg_write_arbiter
//
// Arbitrates the shared register-bank load path between several write
// requesters. One requester is granted at a time. The arbiter latches the
// winner's address and data, then spends one LOAD cycle driving the shared bus
// and the active-low load strobe of the target register. The bank registers are
// clocked on the falling edge, so they capture the write in the middle of the
// LOAD cycle.
//
// Build option:
//   ARB_FIXED_PRIO_EN - when defined, the lowest-index requester always wins.
//                       When undefined (the default), winners are picked in
//                       round-robin order from a rotating pointer.
//
// Ports:
//   Clk      in  : clock, rising-edge active
//   Reset    in  : asynchronous active-low reset
//   Req      in  : per-requester write request, active-high
//   ReqAddr  in  : packed target addresses, AddrWidth bits per requester
//   ReqData  in  : packed write data, DataWidth bits per requester
//   Gnt      out : one-hot grant, high for the single LOAD cycle
//   LDn      out : per-register load strobe, active-low
//   BusData  out : shared write data; keeps its last value while idle
//   Busy     out : high while in LOAD
//   AddrErr  out : high for a LOAD cycle whose address is >= NumRegs

module reg_write_arbiter #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned NumReq    = 4,
    parameter int unsigned NumRegs   = 8,
    parameter int unsigned AddrWidth = 3
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic [NumReq-1:0]              Req,
    input  logic [NumReq*AddrWidth-1:0]    ReqAddr,
    input  logic [NumReq*DataWidth-1:0]    ReqData,
    output logic [NumReq-1:0]              Gnt,
    output logic [NumRegs-1:0]             LDn,
    output logic [DataWidth-1:0]           BusData,
    output logic                           Busy,
    output logic                           AddrErr
);

    localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [0:0] {StIdle, StLoad} state_e;

    state_e                 state_q, state_d;
    logic [IdxWidth-1:0]    win_idx;
    logic                   req_any;
    logic                   grant_now;
    logic [IdxWidth-1:0]    search_base;
    logic [IdxWidth-1:0]    win_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [DataWidth-1:0]   data_q;

    // Per-requester views of the packed address/data buses.
    logic [AddrWidth-1:0]   req_addr [NumReq];
    logic [DataWidth-1:0]   req_data [NumReq];

    for (genvar i = 0; i < NumReq; i++) begin : g_unpack
        assign req_addr[i] = ReqAddr[i*AddrWidth +: AddrWidth];
        assign req_data[i] = ReqData[i*DataWidth +: DataWidth];
    end

    assign grant_now = (state_q == StIdle) && req_any;

`ifdef ARB_FIXED_PRIO_EN
    // Search always starts at requester 0, so the lowest set bit wins.
    assign search_base = '0;
`else
    logic [IdxWidth-1:0] ptr_q;

    assign search_base = ptr_q;

    // Pointer moves to the slot just after the winner, wrapping at NumReq.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ptr_q <= '0;
        end else if (grant_now) begin
            if (32'(win_idx) == NumReq - 1) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= win_idx + 1'b1;
            end
        end
    end
`endif

    // Winner search: first requesting slot at or after search_base, modulo NumReq.
    always_comb begin
        int unsigned         cand;
        logic [IdxWidth-1:0] cand_idx;
        win_idx  = '0;
        req_any  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 0; off < NumReq; off++) begin
            cand     = (32'(search_base) + off) % NumReq;
            cand_idx = IdxWidth'(cand);
            if (!req_any && Req[cand_idx]) begin
                req_any = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Req is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = grant_now ? StLoad : StIdle;
            StLoad:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Latched write. data_q doubles as the bus register, so it holds while idle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            win_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else if (grant_now) begin
            win_q  <= win_idx;
            addr_q <= req_addr[win_idx];
            data_q <= req_data[win_idx];
        end
    end

    assign BusData = data_q;

    // Outputs decode only registered state, so there is no path from Req, and
    // the asynchronous reset of state_q pulls LDn high immediately.
    always_comb begin
        Gnt     = '0;
        LDn     = '1;
        Busy    = 1'b0;
        AddrErr = 1'b0;
        if (state_q == StLoad) begin
            Busy       = 1'b1;
            Gnt[win_q] = 1'b1;
            if (32'(addr_q) >= NumRegs) begin
                AddrErr = 1'b1;
            end else begin
                for (int unsigned r = 0; r < NumRegs; r++) begin
                    if (32'(addr_q) == r) begin
                        LDn[r] = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Shares the softcore's register bank load path between several write requesters (ALU writeback, memory load unit, debug port, interrupt logic). Grants one requester at a time, round-robin. Drives the shared data bus and the active-low per-register load strobes that the bank's negedge-clocked registers consume. Sits between the execution-stage writeback sources and the register instances.

## Interface
- `DataWidth`, 8, width of register data and the shared bus
- `NumReq`, 4, number of requesters (2..8)
- `NumRegs`, 8, number of registers in the bank (2..2^AddrWidth)
- `AddrWidth`, 3, register address width

- `Clk` in 1: clock; this block acts on the rising edge
- `Reset` in 1: asynchronous, active-low reset
- `Req` in NumReq: per-requester write request, active-high
- `ReqAddr` in NumReq*AddrWidth: packed target addresses; requester i uses bits [i*AddrWidth +: AddrWidth]
- `ReqData` in NumReq*DataWidth: packed write data; requester i uses bits [i*DataWidth +: DataWidth]
- `Gnt` out NumReq: one-hot grant pulse, one cycle, meaning the write is accepted
- `LDn` out NumRegs: per-register load strobe, active-low, connected to each register's LD
- `BusData` out DataWidth: shared write data, connected to every register's DIn
- `Busy` out 1: high while in LOAD
- `AddrErr` out 1: one-cycle pulse for a granted write whose address is >= NumRegs

## Operation
- FSM states:
  - IDLE:
    - if any `Req` bit is set at a rising edge, select the winner, latch its index, address and data, and go to LOAD
    - otherwise stay in IDLE
  - LOAD:
    - always returns to IDLE at the next rising edge
    - `Req` is not sampled in LOAD
- Winner selection: round-robin.
  - Search starts at pointer `Ptr` and wraps modulo NumReq.
  - On entering LOAD, `Ptr` = (winner+1) mod NumReq.
  - `Ptr` reset value is 0.
- Outputs in LOAD are registered, with no combinational path from `Req`:
  - `LDn[addr]` = 0, all other `LDn` bits = 1
  - `BusData` = latched data
  - `Gnt[winner]` = 1
  - `Busy` = 1
- Outputs in IDLE:
  - `LDn` all ones, `Gnt` = 0, `Busy` = 0, `AddrErr` = 0
  - `BusData` holds its last value
- Address out of range (latched addr >= NumRegs):
  - `Gnt` still pulses
  - `LDn` stays all ones
  - `AddrErr` = 1 for the LOAD cycle
- Requester contract:
  - hold `Req`, `ReqAddr` and `ReqData` stable until `Gnt` is seen
  - deassert `Req` before the next rising edge
  - a `Req` still high one cycle after its `Gnt` is a new request
- Dropping `Req` during LOAD has no effect; the latched write completes.
- Reset values (asynchronous, applied immediately on `Reset`=0): state IDLE, `Ptr`=0, `LDn` all ones, `Gnt`=0, `BusData`=0, `Busy`=0, `AddrErr`=0.

## Timing
- `Req` sampled at rising edge k (state IDLE) → LOAD during cycle k..k+1.
- The target register loads `BusData` at the falling edge inside that cycle, because the bank is negedge-clocked. `LDn`/`BusData` are therefore stable half a cycle before the load.
- Latency from request to register update: 1.5 cycles.
- Throughput: at most one write per 2 cycles.
- Back-to-back requests from different requesters are granted at edges k, k+2, k+4, and so on.
- `Reset` asserted during LOAD:
  - `LDn` returns to all ones asynchronously and no load occurs
  - the in-flight write is dropped and no `Gnt` is delivered after reset
  - the requester must re-request

## Configuration
- `ARB_FIXED_PRIO_EN`:
  - defined: fixed priority, where the lowest-index requesting bit always wins and `Ptr` is neither used nor updated
  - undefined (default): round-robin as described above
- All other behaviour is identical in both builds.

## Test plan
- Reset: drive `Reset`=0 mid-run → `LDn`=8'hFF, `Gnt`=0, `Busy`=0, `BusData`=0, `AddrErr`=0 immediately, without waiting for a clock edge.
- Single write: `Req`=4'b0100, addr2=5, data2=8'hA5 → next cycle `LDn`=8'b1101_1111, `BusData`=8'hA5, `Gnt`=4'b0100 for exactly one cycle, register 5 = 8'hA5 after the falling edge, IDLE the following cycle.
- Round-robin: all four `Req` held high from reset, each dropped one cycle after its own `Gnt` and re-raised → grants 0,1,2,3,0 at edges 1,3,5,7,9. With `ARB_FIXED_PRIO_EN` and `Req[0]` always re-raised, only requester 0 is granted.
- Out of range: `NumRegs`=6, `Req[1]` with addr=7 → `Gnt`=4'b0010 and `AddrErr`=1 for one cycle, `LDn` all ones, no register changes.
- Reset mid-LOAD: assert `Reset` at the quarter point of the LOAD cycle → `LDn` all ones before the falling edge, target register unchanged, `Ptr`=0 so requester 0 wins first after release.
